// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl
//   Input-side producer for the snake game-logic block. It conditions the four
//   raw board push-buttons, turns presses into a held direction and issues
//   the periodic move strobe.
//
//   Processing chain, per button:
//     2-FF synchroniser -> debounce counter -> one-cycle press pulse.
//   The press pulses go through a fixed priority (Top > Bottom > Left > Right).
//   The winning request is screened against the committed direction, so that
//   180-degree reversals can be refused. A request that passes the screen is
//   stored as the pending direction. On each move tick, pending is copied to
//   accion and mover pulses for one cycle.
//
// Ports:
//   uclk       system clock
//   reset      asynchronous reset, active low
//   BtnTop     raw button (active high, asynchronous to uclk)
//   BtnBottom  raw button
//   BtnLeft    raw button
//   BtnRight   raw button
//   enable     1 = game running, 0 = paused (tick counter frozen)
//   accion     committed direction: 0 none, 1 up, 2 down, 3 left, 4 right
//   mover      one-cycle move strobe; accion is already updated while it is high

// Per-button conditioning: synchroniser, debounce and press detection.
//   btn    raw button level
//   press  one-cycle pulse on the first cycle the debounced state reads 1
module snake_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 23
) (
  input  logic uclk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic [1:0]       sync_pipe;
  logic [CNT_W-1:0] cnt;
  logic             state;
  logic             differ;
  logic             settle;

  assign differ = sync_pipe[1] ^ state;
  assign settle = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge uclk or negedge reset) begin
    if (!reset) begin
      sync_pipe <= '0;
      cnt       <= '0;
      state     <= 1'b0;
      press     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], btn};
      press     <= 1'b0;
      if (!differ) begin
        // Any agreement restarts the run, so only an unbroken run flips state.
        cnt <= '0;
      end else if (settle) begin
        cnt   <= '0;
        state <= sync_pipe[1];
        // This is a rising edge only when the new state is 1. A release
        // does not produce a press.
        press <= sync_pipe[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

module snake_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 5000000,
  parameter int CNT_W           = 23,
  parameter bit ALLOW_REVERSE   = 1'b0
) (
  input  logic       uclk,
  input  logic       reset,
  input  logic       BtnTop,
  input  logic       BtnBottom,
  input  logic       BtnLeft,
  input  logic       BtnRight,
  input  logic       enable,
  output logic [2:0] accion,
  output logic       mover
);

  localparam int NUM_BTNS = 4;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef struct packed {
    logic vld;
    dir_t dir;
  } req_t;

  // Bit order matches the priority order: index 0 has the highest priority.
  logic [NUM_BTNS-1:0] btn;
  logic [NUM_BTNS-1:0] press;

  assign btn = {BtnRight, BtnLeft, BtnBottom, BtnTop};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    snake_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .uclk  (uclk),
      .reset (reset),
      .btn   (btn[i]),
      .press (press[i])
    );
  end

  // Fixed-priority pick among simultaneous presses.
  req_t req;

  always_comb begin
    req = '{vld: 1'b0, dir: DIR_NONE};
    if (press[0])      req = '{vld: 1'b1, dir: DIR_UP};
    else if (press[1]) req = '{vld: 1'b1, dir: DIR_DOWN};
    else if (press[2]) req = '{vld: 1'b1, dir: DIR_LEFT};
    else if (press[3]) req = '{vld: 1'b1, dir: DIR_RIGHT};
  end

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_NONE;
    endcase
  endfunction

  dir_t accion_q;
  dir_t pending;
  logic reversal;
  logic accept;

  // Reversal is judged against what the snake is actually doing (accion_q),
  // not against an uncommitted pending choice. Because opposite(DIR_NONE) is
  // DIR_NONE and req.dir is never DIR_NONE when valid, nothing is refused
  // while the snake has no committed direction.
  assign reversal = (accion_q != DIR_NONE) && (req.dir == opposite(accion_q));
  assign accept   = req.vld && (ALLOW_REVERSE || !reversal);

  logic [CNT_W-1:0] tick_cnt;
  logic             wrap;

  assign wrap = enable && (tick_cnt == CNT_W'(TICK_CYCLES - 1));

  always_ff @(posedge uclk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      mover    <= 1'b0;
      accion_q <= DIR_NONE;
      pending  <= DIR_NONE;
    end else begin
      mover <= 1'b0;
      if (wrap) begin
        tick_cnt <= '0;
        mover    <= 1'b1;
        accion_q <= pending;
      end else if (enable) begin
        tick_cnt <= tick_cnt + CNT_W'(1);
      end
      // A request accepted on the wrap edge lands in pending after the commit
      // above has sampled the old value, so it takes effect on the next tick.
      // Pending is never cleared on commit, so the held direction persists.
      if (accept) pending <= req.dir;
    end
  end

  assign accion = accion_q;

endmodule

// File: doc/snake_input_ctrl.md
Name: snake_input_ctrl

Overview:
- Input-side producer for the game-logic block: drives the `accion` direction code and the `mover` step strobe that the game-logic block consumes.
- Conditions the four raw board push-buttons: 2-FF synchroniser, then debounce.
- Turns button presses into one held direction; a 180° reversal is not allowed.
- Generates the periodic move tick. Sits between the board buttons and the game-logic block.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive cycles a synchronised button must disagree with its debounced state before that state flips (10 ms at 50 MHz).
- TICK_CYCLES, 5000000: uclk cycles per move tick (10 steps/s at 50 MHz).
- CNT_W, 23: width of the debounce and tick counters; must hold max(DEBOUNCE_CYCLES, TICK_CYCLES)-1.
- ALLOW_REVERSE, 0: 1 permits 180° reversal requests.

Ports:
- uclk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- BtnTop  input  1  raw button, active-high, asynchronous to uclk.
- BtnBottom  input  1  raw button, active-high.
- BtnLeft  input  1  raw button, active-high.
- BtnRight  input  1  raw button, active-high.
- enable  input  1  1 = game running; 0 = paused, tick frozen.
- accion  output  3  committed direction: 0 none, 1 up, 2 down, 3 left, 4 right. Registered.
- mover  output  1  one-cycle-high move strobe. Registered.

Behaviour:
- Reset (reset=0, asynchronous) clears everything immediately, no clock needed:
  - accion=0, mover=0.
  - Synchroniser FFs, debounced states, debounce counters, tick counter and pending direction all 0.
- Synchroniser: 2 flops per button; button-to-debouncer latency is 2 cycles.
- Debounce, per button:
  - Counter resets to 0 whenever the synchronised input equals the debounced state.
  - Otherwise the counter increments. On the cycle it reaches DEBOUNCE_CYCLES-1, the debounced state takes the synchronised value and the counter clears.
  - A disagreement run shorter than DEBOUNCE_CYCLES never changes the state.
- Press event: a 0→1 transition of a debounced state, lasting one cycle. A release produces no event.
- Request selection: if several press events occur in the same cycle, priority is Top > Bottom > Left > Right. Only the winner is considered.
- Request acceptance, checked against the committed `accion`, not the pending direction:
  - Rejected if ALLOW_REVERSE=0, accion≠0 and the request is the opposite of accion (1↔2, 3↔4).
  - Otherwise it overwrites the pending direction. A later accepted press before the next tick also overwrites (last accepted wins).
  - Presses are accepted while enable=0.
- Tick counter:
  - With enable=1 it counts 0..TICK_CYCLES-1 and wraps to 0.
  - On the wrap cycle edge, mover←1 and accion←pending, in the same edge, so the consumer sees the new accion while mover=1.
  - mover←0 on every other edge, so mover is never high for two consecutive cycles.
  - With enable=0 the counter holds its value and mover=0. Resuming continues from the held count.
- The first tick occurs TICK_CYCLES cycles after reset deasserts with enable=1.
- Ticks occur even while accion=0; the consumer ignores code 0.
- A press accepted in the same cycle as the tick wrap is committed at the following tick, not this one.
- Codes 5..7 are never produced.
- Pending resets only via reset; it is not cleared on commit, so the held direction persists.

Test Plan:
(DEBOUNCE_CYCLES=4, TICK_CYCLES=10, CNT_W=4, enable=1 unless stated)
- Reset release, no buttons -> mover=1 alone at cycles 10, 20, 30 after deassertion; accion=0 throughout.
- BtnRight high for 8 cycles, starting just after a tick -> pending=4 (2-cycle sync + 4-cycle debounce); at the next tick accion=4 on the same edge as mover=1; accion stays 4 on later ticks.
- BtnTop bounced in 3-cycle-high / 2-cycle-low bursts for 30 cycles -> debounced state never flips; accion unchanged.
- accion=4, press BtnLeft -> rejected, accion stays 4. Between ticks press BtnTop then BtnLeft -> accion=1 at the next tick, and it stays 1 on the following tick. With ALLOW_REVERSE=1, pressing BtnLeft while accion=4 gives accion=3.
- BtnTop and BtnRight debounced in the same cycle with accion=0 -> accion=1 at the next tick.
- enable=0 at count 6 for 25 cycles -> no mover; on resume the first mover comes 4 cycles later. Then reset=0 mid-count -> accion=0 and mover=0 asynchronously. After release the first tick is 10 cycles later.
